// File: rtl/rr_arb4to1_n.sv
// rtl/rr_arb4to1_n.sv - round-robin 4:1 arbiter with one-entry valid/ready output register
module rr_arb4to1_n #(
  parameter int n       = 4,
  parameter int address = 2,
  parameter int m       = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [m-1:0]       req_i,
  output logic [m-1:0]       ack_o,
  output logic [address-1:0] sel_o,
  input  logic [n-1:0]       mux_data_i,
  output logic [n-1:0]       data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  logic [address-1:0] ptr_q, ptr_d;
  logic [address-1:0] last_sel_q, last_sel_d;
  logic [n-1:0]       data_q, data_d;
  logic               valid_q, valid_d;

  logic [address-1:0] win;
  logic [address-1:0] cand;
  logic               found;
  logic               any_req;
  logic               cap_en;
  logic               sel_live;
  logic               grant;

  assign any_req = |req_i;
  // Register can take a new item when empty or when its current item leaves this cycle.
  assign cap_en  = !valid_q || ready_i;
  // sel_live depends only on req/flush/state, never on mux_data_i, so the mux path has no loop.
  assign sel_live = cap_en && any_req && !flush_i;
  // Reset suppresses the ack so a held requester is not told its data was taken.
  assign grant    = sel_live && !rst_i;

  // Scan requesters starting at ptr and wrapping; first one asserting wins.
  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < m; i++) begin
      cand = ptr_q + address'(i);
      if (!found && req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Select follows the live winner while granting, otherwise parks on the last grant.
  always_comb begin
    sel_o = last_sel_q;
    ack_o = '0;
    if (sel_live) begin
      sel_o = win;
    end
    if (grant) begin
      ack_o = m'(1) << win;
    end
  end

  // Next-state: flush beats capture; capture beats plain drain.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    last_sel_d = last_sel_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (grant) begin
      valid_d    = 1'b1;
      data_d     = mux_data_i;
      last_sel_d = win;
      ptr_d      = win + address'(1);
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      ptr_q      <= '0;
      last_sel_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      ptr_q      <= ptr_d;
      last_sel_q <= last_sel_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_arb4to1_n.sv
// tb/tb_rr_arb4to1_n.sv - scoreboard bench for rr_arb4to1_n
module tb_rr_arb4to1_n;

  logic       clk;
  logic       rst_i;
  logic       flush_i;
  logic [3:0] req_i;
  logic [3:0] ack_o;
  logic [1:0] sel_o;
  logic [7:0] mux_data;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  rr_arb4to1_n #(.n(8), .address(2), .m(4)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .req_i(req_i),
    .ack_o(ack_o),
    .sel_o(sel_o),
    .mux_data_i(mux_data),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  assign mux_data = 8'hA0 + 8'(sel_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic [3:0] rq, input logic rdy, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    req_i   = rq;
    ready_i = rdy;
    flush_i = fl;
    rst_i   = rs;
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string name, input logic [3:0] ack, input logic [1:0] sel,
                            input logic vld);
    chk({name, "_ack"}, 32'(ack_o), 32'(ack));
    chk({name, "_sel"}, 32'(sel_o), 32'(sel));
    chk({name, "_valid"}, 32'(valid_o), 32'(vld));
  endtask

  // Monitor: every accepted item is compared against the oldest expected capture.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1 && (flush_i || rst_i)) begin
        if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      end else if (valid_o === 1'b1 && ready_i) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_item: got %0h expected none", data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("accepted_data", 32'(data_o), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_i = 4'b1111; ready_i = 1'b1;

    // 1. reset with requests pending
    @(negedge clk);
    chk("rst1_valid", 32'(valid_o), 0);
    chk("rst1_data", 32'(data_o), 0);
    chk("rst1_ack", 32'(ack_o), 0);
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    chk("rst2_valid", 32'(valid_o), 0);
    chk("rst2_data", 32'(data_o), 0);
    chk("rst2_ack", 32'(ack_o), 0);

    // 2. round-robin with all requesting
    step(4'b1111, 1'b1, 1'b0, 1'b0); expect_cyc("rr0", 4'b0001, 2'd0, 1'b0); exp_q.push_back(8'hA0);
    step(4'b1111, 1'b1, 1'b0, 1'b0); expect_cyc("rr1", 4'b0010, 2'd1, 1'b1); exp_q.push_back(8'hA1);
    step(4'b1111, 1'b1, 1'b0, 1'b0); expect_cyc("rr2", 4'b0100, 2'd2, 1'b1); exp_q.push_back(8'hA2);
    step(4'b1111, 1'b1, 1'b0, 1'b0); expect_cyc("rr3", 4'b1000, 2'd3, 1'b1); exp_q.push_back(8'hA3);
    step(4'b1111, 1'b1, 1'b0, 1'b0); expect_cyc("rr4", 4'b0001, 2'd0, 1'b1); exp_q.push_back(8'hA0);

    // 3. backpressure: capture requester 2, then hold for three cycles
    step(4'b0100, 1'b1, 1'b0, 1'b0); expect_cyc("bp_cap", 4'b0100, 2'd2, 1'b1); exp_q.push_back(8'hA2);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 1'b0, 1'b0, 1'b0);
      expect_cyc("bp_hold", 4'b0000, 2'd2, 1'b1);
      chk("bp_hold_data", 32'(data_o), 32'h0000_00A2);
    end
    step(4'b0011, 1'b1, 1'b0, 1'b0); expect_cyc("bp_release", 4'b0001, 2'd0, 1'b1); exp_q.push_back(8'hA0);

    // 4. sparse requests and pointer wrap
    step(4'b0100, 1'b1, 1'b0, 1'b0); expect_cyc("sp0", 4'b0100, 2'd2, 1'b1); exp_q.push_back(8'hA2);
    step(4'b0100, 1'b1, 1'b0, 1'b0); expect_cyc("sp_wrap", 4'b0100, 2'd2, 1'b1); exp_q.push_back(8'hA2);
    step(4'b1000, 1'b1, 1'b0, 1'b0); expect_cyc("sp3", 4'b1000, 2'd3, 1'b1); exp_q.push_back(8'hA3);
    step(4'b0010, 1'b1, 1'b0, 1'b0); expect_cyc("sp1", 4'b0010, 2'd1, 1'b1); exp_q.push_back(8'hA1);

    // 5. flush wins over a simultaneous capture; pointer stays at 2
    step(4'b0001, 1'b1, 1'b1, 1'b0); expect_cyc("flush", 4'b0000, 2'd1, 1'b1);
    step(4'b0011, 1'b1, 1'b0, 1'b0); expect_cyc("post_flush", 4'b0001, 2'd0, 1'b0); exp_q.push_back(8'hA0);

    // 6. reset during hold discards the item; next grant from requester 0
    step(4'b0000, 1'b0, 1'b0, 1'b0); expect_cyc("hold", 4'b0000, 2'd0, 1'b1);
    chk("hold_data", 32'(data_o), 32'h0000_00A0);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_ack", 32'(ack_o), 0);
    step(4'b1111, 1'b0, 1'b0, 1'b0); expect_cyc("after_rst", 4'b0001, 2'd0, 1'b0);
    chk("after_rst_data", 32'(data_o), 0);
    exp_q.push_back(8'hA0);
    step(4'b0000, 1'b1, 1'b0, 1'b0); expect_cyc("drain", 4'b0000, 2'd0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b0); expect_cyc("drained", 4'b0000, 2'd0, 1'b0);
    chk("stale_data", 32'(data_o), 32'h0000_00A0);

    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
